// File: rtl/mempool_pkg.sv
// Shared MemPool DMA types: frontend/backend request, status meta and split FSM states.
// No logic; widths here set the payload of every DMA handshake in the group.
// Backpressure is defined by the modules using these types.
package mempool_pkg;

    localparam int unsigned NumDmasPerGroup = 4;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] num_bytes;
        logic [3:0]  id;
        logic        decouple_rw;
        logic        deburst;
        logic        serialize;
    } dma_req_t;

    typedef struct packed {
        logic backend_idle;
        logic trans_complete;
    } dma_meta_t;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_SPLIT,
        DMA_WAIT
    } dma_split_state_e;

    function automatic logic [31:0] min_len(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/mempool_dma_split_cnt.sv
// Saturating up/down counter of in-flight chunks for one DMA backend.
// Latency: flags from registered count; empty_next_o reflects the count after this edge.
// Backpressure: none itself; full_o gates the issuer, decrements at zero are dropped.
module mempool_dma_split_cnt #(
    parameter int unsigned MaxCount = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o,
    output logic empty_next_o
);

    localparam int unsigned CntW = $clog2(MaxCount + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxCount);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            inc_ok, dec_ok;

    always_comb begin
        cnt_d  = cnt_q;
        inc_ok = inc_i && (cnt_q != CntMax);
        dec_ok = dec_i && (cnt_q != '0);
        if (inc_ok && !dec_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!inc_ok && dec_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full_o       = (cnt_q == CntMax);
    assign empty_o      = (cnt_q == '0);
    assign empty_next_o = (cnt_d == '0);

endmodule

// File: rtl/mempool_dma_split.sv
// Splits one frontend DMA transfer into ChunkBytes-aligned chunks routed round-robin by dst to backends.
// Latency: first chunk valid one cycle after frontend handshake; completion one cycle after last backend completion.
// Backpressure: per-backend valid/ready plus MaxOutstanding credit; MEMPOOL_DMA_SPLIT_STATS_EN enables stat counters.
module mempool_dma_split
    import mempool_pkg::*;
#(
    parameter int unsigned NumBackends    = mempool_pkg::NumDmasPerGroup,
    parameter int unsigned ChunkBytes     = 1024,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  dma_req_t                      req_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    output dma_req_t  [NumBackends-1:0]   be_req_o,
    output logic      [NumBackends-1:0]   be_valid_o,
    input  logic      [NumBackends-1:0]   be_ready_i,
    input  dma_meta_t [NumBackends-1:0]   be_meta_i,
    output dma_meta_t                     meta_o,
    output logic      [31:0]              stat_chunks_o,
    output logic      [31:0]              stat_stalls_o
);

    localparam int unsigned OffW = $clog2(ChunkBytes);

    if ((ChunkBytes < 4) || ((ChunkBytes & (ChunkBytes - 1)) != 0)) begin : g_bad_chunk
        $error("ChunkBytes must be a power of two >= 4");
    end
    if (NumBackends < 1) begin : g_bad_backends
        $error("NumBackends must be >= 1");
    end
    if (MaxOutstanding < 1) begin : g_bad_outstanding
        $error("MaxOutstanding must be >= 1");
    end

    dma_split_state_e state_q, state_d;
    dma_req_t         req_q, req_d;
    logic             cpl_q, cpl_d;
    logic [31:0]      room, cur_len, chunk_idx;
    logic [NumBackends-1:0] full, empty, empty_next, be_hs, be_idle;
    logic             hs;

    // req_q holds the not-yet-issued tail: dst/src of the next chunk and bytes left.
    assign room      = 32'(ChunkBytes) - 32'(req_q.dst[OffW-1:0]);
    assign cur_len   = min_len(req_q.num_bytes, room);
    assign chunk_idx = (req_q.dst >> OffW) % 32'(NumBackends);

    always_comb begin
        be_valid_o = '0;
        be_req_o   = '0;
        for (int k = 0; k < NumBackends; k++) begin
            if ((state_q == DMA_SPLIT) && (chunk_idx == 32'(k)) && !full[k]) begin
                be_valid_o[k]          = 1'b1;
                be_req_o[k]            = req_q;
                be_req_o[k].num_bytes  = cur_len;
            end
        end
    end

    assign be_hs = be_valid_o & be_ready_i;
    assign hs    = |be_hs;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cpl_d   = 1'b0;
        case (state_q)
            DMA_IDLE: begin
                if (req_valid_i) begin
                    req_d   = req_i;
                    state_d = (req_i.num_bytes == '0) ? DMA_WAIT : DMA_SPLIT;
                end
            end
            DMA_SPLIT: begin
                if (hs) begin
                    req_d.src       = req_q.src + cur_len;
                    req_d.dst       = req_q.dst + cur_len;
                    req_d.num_bytes = req_q.num_bytes - cur_len;
                    if (req_q.num_bytes == cur_len) begin
                        state_d = DMA_WAIT;
                    end
                end
            end
            DMA_WAIT: begin
                // Look at next-cycle counts so the pulse lands one cycle after the last completion.
                if (&empty_next) begin
                    cpl_d   = 1'b1;
                    state_d = DMA_IDLE;
                end
            end
            default: state_d = DMA_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DMA_IDLE;
            req_q   <= '0;
            cpl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cpl_q   <= cpl_d;
        end
    end

    assign req_ready_o           = (state_q == DMA_IDLE);
    assign meta_o.backend_idle   = (state_q == DMA_IDLE) && (&be_idle);
    assign meta_o.trans_complete = cpl_q;

    for (genvar k = 0; k < NumBackends; k++) begin : g_cnt
        assign be_idle[k] = be_meta_i[k].backend_idle;

        mempool_dma_split_cnt #(
            .MaxCount (MaxOutstanding)
        ) i_cnt (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .inc_i        (be_hs[k]),
            .dec_i        (be_meta_i[k].trans_complete),
            .full_o       (full[k]),
            .empty_o      (empty[k]),
            .empty_next_o (empty_next[k])
        );

        a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            be_meta_i[k].trans_complete |-> !empty[k]);
    end

`ifdef MEMPOOL_DMA_SPLIT_STATS_EN
    logic [31:0] chunks_q, stalls_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chunks_q <= '0;
            stalls_q <= '0;
        end else begin
            if (hs && (chunks_q != '1)) begin
                chunks_q <= chunks_q + 32'd1;
            end
            if ((state_q == DMA_SPLIT) && !hs && (stalls_q != '1)) begin
                stalls_q <= stalls_q + 32'd1;
            end
        end
    end

    assign stat_chunks_o = chunks_q;
    assign stat_stalls_o = stalls_q;
`else
    assign stat_chunks_o = '0;
    assign stat_stalls_o = '0;
`endif

endmodule
